input_skew_feeder: RTL

Front-end skew buffer for the N×N systolic matrix-multiply grid, mirroring the output deskew stage at the far side of the array. It accepts one N-element operand vector per cycle over a valid/ready handshake and emits element i on lane i delayed by i cycles, producing the diagonal wavefront the grid expects. A small state machine tracks matrix boundaries, drains the skew pipeline after the last vector, and signals completion.

---
 rtl/input_skew_feeder_if.sv | 13 +
 rtl/input_skew_feeder.sv | 103 ++++++++++
 2 files changed

// File: rtl/input_skew_feeder_if.sv
// rtl/input_skew_feeder_if.sv - operand-vector handshake into the skew feeder
interface input_skew_feeder_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic [N-1:0][DATA_WIDTH-1:0] in_row;

  modport master (output in_valid, output in_last, output in_row, input in_ready);
  modport slave  (input in_valid, input in_last, input in_row, output in_ready);
endinterface

// File: rtl/input_skew_feeder.sv
// rtl/input_skew_feeder.sv - diagonal-wavefront skew buffer feeding the systolic grid edge
module input_skew_feeder #(
  parameter int N           = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input_skew_feeder_if.slave           bus,
  output logic [N-1:0][DATA_WIDTH-1:0] lane_data,
  output logic [N-1:0]                 lane_valid,
  output logic                         busy,
  output logic                         done,
  output logic [COUNT_WIDTH-1:0]       row_count
);
  localparam int FW = (N > 1) ? $clog2(N) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(N - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t        state;
  logic [FW-1:0] flush_cnt;
  logic          fire;

  assign bus.in_ready = reset_n && (state != FLUSH);
  assign fire         = bus.in_valid && bus.in_ready;

  // Lane i: i delay stages plus an output stage; idle cycles inject zero bubbles.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] d [0:i];
    logic                  v [0:i];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int k = 0; k <= i; k++) begin
          d[k] <= '0;
          v[k] <= 1'b0;
        end
      end else begin
        d[0] <= fire ? bus.in_row[i] : '0;
        v[0] <= fire;
        for (int k = 1; k <= i; k++) begin
          d[k] <= d[k-1];
          v[k] <= v[k-1];
        end
      end
    end

    assign lane_data[i]  = d[i];
    assign lane_valid[i] = v[i];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      row_count <= '0;
      flush_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fire) begin
            row_count <= COUNT_WIDTH'(1);
            busy      <= 1'b1;
            if (bus.in_last) begin
              state     <= FLUSH;
              flush_cnt <= '0;
              done      <= (N == 1);
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (fire) begin
            if (row_count != '1) row_count <= row_count + 1'b1;
            if (bus.in_last) begin
              state     <= FLUSH;
              flush_cnt <= '0;
              done      <= (N == 1);
            end
          end
        end
        FLUSH: begin
          // done lands on the cycle the last vector's element exits lane N-1.
          if (flush_cnt == FLUSH_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
            done      <= ((flush_cnt + 1'b1) == FLUSH_LAST);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
